// File: rtl/sensor_conditioner.sv
// Photo-sensor front end: per-channel sync, debounce, rising-edge one-shot, stuck-beam flag.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges raw-to-pulse; no backpressure, pulses are fire-and-forget.
module sensor_channel #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int STUCK_CYCLES    = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse,
  output logic level,
  output logic stuck
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCNT_MAX  = SW'(STUCK_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic [SW-1:0]          scnt_q, scnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   stuck_q, stuck_d;
  logic                   sync_x;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
    sync_x  = sync_q[SYNC_STAGES-1];
    dcnt_d  = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    // Any sample matching the current level drops the count, so glitches are discarded.
    if (sync_x != level_q) begin
      if (dcnt_q == DCNT_LAST) begin
        level_d = sync_x;
        pulse_d = sync_x;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end

    scnt_d  = '0;
    stuck_d = 1'b0;
    // Stuck clears on the same edge the level falls, hence level_d.
    if (level_q) begin
      scnt_d  = (scnt_q == SCNT_MAX) ? scnt_q : scnt_q + 1'b1;
      stuck_d = level_d && (scnt_d == SCNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      dcnt_q  <= '0;
      scnt_q  <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      dcnt_q  <= dcnt_d;
      scnt_q  <= scnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      stuck_q <= stuck_d;
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;
  assign stuck = stuck_q;
endmodule

module sensor_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int STUCK_CYCLES    = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_a_raw,
  input  logic sensor_b_raw,
  output logic sensor_a,
  output logic sensor_b,
  output logic a_level,
  output logic b_level,
  output logic a_stuck,
  output logic b_stuck
);
  sensor_channel #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)
  ) u_chan_a (
    .clk(clk), .rst(rst), .raw(sensor_a_raw),
    .pulse(sensor_a), .level(a_level), .stuck(a_stuck)
  );

  sensor_channel #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)
  ) u_chan_b (
    .clk(clk), .rst(rst), .raw(sensor_b_raw),
    .pulse(sensor_b), .level(b_level), .stuck(b_stuck)
  );
endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: directed scenarios plus randomized beams against a window-based model.
module tb_sensor_conditioner;
  localparam int S  = 2;
  localparam int D  = 8;
  localparam int ST = 16;

  logic clk, rst, sensor_a_raw, sensor_b_raw;
  logic sensor_a, sensor_b, a_level, b_level, a_stuck, b_stuck;
  logic [5:0] dut_vec;
  int checks, errors;

  // Model: level flips when the last D synchronized samples all differ from it.
  logic hist [2][0:4095];
  logic lvl [2];
  logic pls [2];
  logic stk [2];
  int   run [2];
  int   edge_n;

  sensor_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .STUCK_CYCLES(ST)) dut (
    .clk(clk), .rst(rst), .sensor_a_raw(sensor_a_raw), .sensor_b_raw(sensor_b_raw),
    .sensor_a(sensor_a), .sensor_b(sensor_b), .a_level(a_level), .b_level(b_level),
    .a_stuck(a_stuck), .b_stuck(b_stuck)
  );

  assign dut_vec = {sensor_a, sensor_b, a_level, b_level, a_stuck, b_stuck};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] exp_vec();
    return {pls[0], pls[1], lvl[0], lvl[1], stk[0], stk[1]};
  endfunction

  task automatic model_clear();
    edge_n = 0;
    for (int ch = 0; ch < 2; ch++) begin
      lvl[ch] = 1'b0; pls[ch] = 1'b0; stk[ch] = 1'b0; run[ch] = 0;
    end
  endtask

  task automatic model_edge(input logic ra, input logic rb);
    logic r [2];
    r[0] = ra; r[1] = rb;
    edge_n++;
    for (int ch = 0; ch < 2; ch++) begin
      logic prev, flip, v;
      hist[ch][edge_n] = r[ch];
      prev = lvl[ch];
      flip = 1'b1;
      // Raw sampled at edge k reaches the debounce logic ahead of edge k+S.
      for (int k = edge_n - S - D + 1; k <= edge_n - S; k++) begin
        v = (k >= 1) ? hist[ch][k] : 1'b0;
        if (v == prev) flip = 1'b0;
      end
      if (prev && run[ch] < ST) run[ch]++;
      lvl[ch] = flip ? ~prev : prev;
      pls[ch] = flip && !prev;
      if (!lvl[ch]) run[ch] = 0;
      stk[ch] = lvl[ch] && (run[ch] >= ST);
    end
  endtask

  task automatic tick(input logic a, input logic b);
    sensor_a_raw = a;
    sensor_b_raw = b;
    @(posedge clk);
    model_edge(a, b);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    sensor_a_raw = 1'b1;
    sensor_b_raw = 1'b0;
    rst = 1'b0;
    model_clear();
    #3;
    checks++;
    if (dut_vec !== 6'b0) begin errors++; $display("FAIL reset_async outputs=%b exp=000000", dut_vec); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== 6'b0) begin errors++; $display("FAIL reset_held outputs=%b exp=000000", dut_vec); end
    rst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_model edge=%0d got=%b exp=%b", i, dut_vec, exp_vec()); end
      if (i == 9 || i == 10 || i == 11) begin
        checks++;
        if (sensor_a !== (i == 10) || a_level !== (i >= 10)) begin
          errors++; $display("FAIL reset_release edge=%0d sensor_a=%b a_level=%b exp=%b/%b", i, sensor_a, a_level, i == 10, i >= 10);
        end
      end
    end
  endtask

  task automatic test_clean_entry();
    int pulses, pulse_edge, fall_edge;
    pulses = 0; pulse_edge = -1; fall_edge = -1;
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      tick(i <= 20, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL entry_model edge=%0d got=%b exp=%b", i, dut_vec, exp_vec()); end
      if (sensor_a) begin pulses++; pulse_edge = i; end
      if (i > 20 && !a_level && fall_edge < 0) fall_edge = i;
    end
    checks++;
    if (pulses != 1 || pulse_edge != 10) begin errors++; $display("FAIL entry_pulse count=%0d edge=%0d exp=1/10", pulses, pulse_edge); end
    checks++;
    if (fall_edge != 30) begin errors++; $display("FAIL entry_fall edge=%0d exp=30", fall_edge); end
  endtask

  task automatic test_glitch();
    int lens [3] = '{5, 7, 8};
    int pulses;
    do_reset();
    for (int t = 0; t < 3; t++) begin
      pulses = 0;
      for (int i = 0; i < lens[t] + 25; i++) begin
        tick(1'b0, i < lens[t]);
        checks++;
        if (dut_vec !== exp_vec()) begin errors++; $display("FAIL glitch_model len=%0d cyc=%0d got=%b exp=%b", lens[t], i, dut_vec, exp_vec()); end
        if (sensor_b) pulses++;
      end
      checks++;
      if (pulses != ((lens[t] >= D) ? 1 : 0) || b_level !== 1'b0) begin
        errors++; $display("FAIL glitch_len%0d pulses=%0d b_level=%b exp=%0d/0", lens[t], pulses, b_level, (lens[t] >= D) ? 1 : 0);
      end
    end
  endtask

  task automatic test_simultaneous();
    int pa, pb, ea, eb;
    pa = 0; pb = 0; ea = -1; eb = -1;
    do_reset();
    for (int i = 1; i <= 27; i++) begin
      tick(i <= 15, i <= 15);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL simul_model edge=%0d got=%b exp=%b", i, dut_vec, exp_vec()); end
      if (sensor_a) begin pa++; ea = i; end
      if (sensor_b) begin pb++; eb = i; end
    end
    checks++;
    if (pa != 1 || pb != 1 || ea != 10 || eb != 10) begin
      errors++; $display("FAIL simul_pulses a=%0d@%0d b=%0d@%0d exp=1@10 1@10", pa, ea, pb, eb);
    end
  endtask

  task automatic test_stuck();
    int pulses, lr, sr, lf, sf;
    pulses = 0; lr = -1; sr = -1; lf = -1; sf = -1;
    do_reset();
    for (int i = 1; i <= 55; i++) begin
      tick(i <= 40, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL stuck_model edge=%0d got=%b exp=%b", i, dut_vec, exp_vec()); end
      if (sensor_a) pulses++;
      if (a_level && lr < 0) lr = i;
      if (a_stuck && sr < 0) sr = i;
      if (i > 40 && !a_level && lf < 0) lf = i;
      if (i > 40 && !a_stuck && sf < 0) sf = i;
    end
    checks++;
    if (sr - lr != ST || pulses != 1) begin errors++; $display("FAIL stuck_rise delay=%0d pulses=%0d exp=%0d/1", sr - lr, pulses, ST); end
    checks++;
    if (sf != lf || lf < 0) begin errors++; $display("FAIL stuck_clear stuck_fall=%0d level_fall=%0d", sf, lf); end
  endtask

  task automatic test_reset_mid();
    int pulses, pe;
    pulses = 0; pe = -1;
    do_reset();
    for (int i = 1; i <= 27; i++) begin
      tick(i > 20, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL midrst_model edge=%0d got=%b exp=%b", i, dut_vec, exp_vec()); end
    end
    #2 rst = 1'b0;
    model_clear();
    #1;
    checks++;
    if (dut_vec !== 6'b0) begin errors++; $display("FAIL midrst_async outputs=%b exp=000000", dut_vec); end
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL midrst_after edge=%0d got=%b exp=%b", i, dut_vec, exp_vec()); end
      if (sensor_a) begin pulses++; pe = i; end
    end
    checks++;
    if (pulses != 1 || pe != 10) begin errors++; $display("FAIL midrst_restart count=%0d edge=%0d exp=1/10", pulses, pe); end
  endtask

  task automatic test_random();
    int la, lb, last_a, last_b;
    logic va, vb;
    la = 0; lb = 0; va = 1'b0; vb = 1'b0; last_a = -1000; last_b = -1000;
    do_reset();
    for (int i = 1; i <= 1500; i++) begin
      if (la == 0) begin va = 1'($urandom_range(0, 1)); la = $urandom_range(1, 24); end
      if (lb == 0) begin vb = 1'($urandom_range(0, 1)); lb = $urandom_range(1, 24); end
      la--; lb--;
      tick(va, vb);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_model edge=%0d got=%b exp=%b", i, dut_vec, exp_vec()); end
      if (sensor_a) begin
        checks++;
        if (i - last_a < 2 * D) begin errors++; $display("FAIL random_rate_a gap=%0d min=%0d", i - last_a, 2 * D); end
        last_a = i;
      end
      if (sensor_b) begin
        checks++;
        if (i - last_b < 2 * D) begin errors++; $display("FAIL random_rate_b gap=%0d min=%0d", i - last_b, 2 * D); end
        last_b = i;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    sensor_a_raw = 1'b0;
    sensor_b_raw = 1'b0;
    model_clear();
    test_reset();
    test_clean_entry();
    test_glitch();
    test_simultaneous();
    test_stuck();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
